// File: rtl/aibcr3_txser_pkg.sv
// Shared types and constants for the word-to-DDR-pair TX serializer.
package aibcr3_txser_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] PAIR_IDLE = 2'b00;

    // Width of a counter that must hold 0..beats-1, never narrower than one bit.
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/aibcr3_txser_fifo.sv
// Single-clock word FIFO with synchronous flush; head is read combinationally.
// Latency: a push is visible at the head one edge later. Backpressure: pushes ignored while full.
module aibcr3_txser_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdat_i,
    output logic [WIDTH-1:0]         rdat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdat_o  = mem_q[rptr_q];

    // Flush wins over any push or pop presented in the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdat_i;
    end

endmodule

// File: rtl/aibcr3_txser.sv
// Word-to-DDR-pair serializer: even bits on odat0, odd on odat1, LSB pair first; optional AIBCR3_TXSER_UNDERRUN_EN flag.
// Latency: word accepted at edge N, first pair valid after edge N+2; back-to-back words stream gap-free.
// Backpressure: owr_rdy low while the FIFO holds DEPTH words, with no pass-through at full.
module aibcr3_txser
    import aibcr3_txser_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              ilaunch_clk,
    input  logic              irstb,
    input  logic              iflush,
    input  logic              iwr_vld,
    input  logic [DWIDTH-1:0] iwr_dat,
    input  logic              iwr_last,
    output logic              owr_rdy,
    output logic              odat0,
    output logic              odat1,
    output logic              obusy
`ifdef AIBCR3_TXSER_UNDERRUN_EN
    ,
    output logic              ounderrun,
    input  logic              iclr_err
`endif
);

    localparam int BEATS = DWIDTH / 2;
    localparam int BW    = beat_width(BEATS);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] sh_q, sh_d;
    logic              last_q, last_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [1:0]        pair_q, pair_d;
    logic              busy_q, busy_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DWIDTH:0]   fifo_rdat;
    logic [AW:0]       fifo_count;
    logic              unused_sig;

    assign owr_rdy = (fifo_count != DEPTH_CNT);
    assign odat0   = pair_q[0];
    assign odat1   = pair_q[1];
    assign obusy   = busy_q;

    aibcr3_txser_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (ilaunch_clk),
        .rst_n_i (irstb),
        .flush_i (iflush),
        .push_i  (iwr_vld & owr_rdy),
        .pop_i   (fifo_pop),
        .wdat_i  ({iwr_last, iwr_dat}),
        .rdat_o  (fifo_rdat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        last_d   = last_q;
        beat_d   = beat_q;
        pair_d   = PAIR_IDLE;
        busy_d   = 1'b0;
        fifo_pop = 1'b0;
        if (iflush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_rdat[DWIDTH-1:0];
                        last_d   = fifo_rdat[DWIDTH];
                        beat_d   = '0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    // The register shifts right so the current pair always sits in bits [1:0].
                    pair_d = sh_q[1:0];
                    busy_d = 1'b1;
                    sh_d   = sh_q >> 2;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            sh_d     = fifo_rdat[DWIDTH-1:0];
                            last_d   = fifo_rdat[DWIDTH];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ilaunch_clk or negedge irstb) begin
        if (!irstb) begin
            state_q <= IDLE;
            sh_q    <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            pair_q  <= PAIR_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            pair_q  <= pair_d;
            busy_q  <= busy_d;
        end
    end

`ifdef AIBCR3_TXSER_UNDERRUN_EN
    logic err_q;
    logic set_err;

    // A word not tagged as burst end ran out with nothing queued behind it.
    assign set_err = ~iflush & (state_q == SHIFT) & (beat_q == LAST_BEAT)
                   & fifo_empty & ~last_q;

    always_ff @(posedge ilaunch_clk or negedge irstb) begin
        if (!irstb) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end else if (iclr_err) begin
            err_q <= 1'b0;
        end
    end

    assign ounderrun  = err_q;
    assign unused_sig = fifo_full;
`else
    assign unused_sig = ^{fifo_full, last_q};
`endif

endmodule

// File: tb/tb_aibcr3_txser.sv
// Scoreboard bench for aibcr3_txser (DWIDTH=8, DEPTH=4); underrun scenario runs when AIBCR3_TXSER_UNDERRUN_EN is defined.
module tb_aibcr3_txser;

    localparam int DWIDTH = 8;
    localparam int DEPTH  = 4;

    logic              ilaunch_clk = 1'b0;
    logic              irstb       = 1'b0;
    logic              iflush      = 1'b0;
    logic              iwr_vld     = 1'b0;
    logic [DWIDTH-1:0] iwr_dat     = '0;
    logic              iwr_last    = 1'b0;
    logic              owr_rdy;
    logic              odat0;
    logic              odat1;
    logic              obusy;
`ifdef AIBCR3_TXSER_UNDERRUN_EN
    logic              ounderrun;
    logic              iclr_err    = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [1:0] exp_q [$];   // each entry {odat0, odat1}

    always #5 ilaunch_clk = ~ilaunch_clk;

    aibcr3_txser #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .ilaunch_clk (ilaunch_clk),
        .irstb       (irstb),
        .iflush      (iflush),
        .iwr_vld     (iwr_vld),
        .iwr_dat     (iwr_dat),
        .iwr_last    (iwr_last),
        .owr_rdy     (owr_rdy),
        .odat0       (odat0),
        .odat1       (odat1),
        .obusy       (obusy)
`ifdef AIBCR3_TXSER_UNDERRUN_EN
        ,
        .ounderrun   (ounderrun),
        .iclr_err    (iclr_err)
`endif
    );

    task automatic drive(input logic vld, input logic [DWIDTH-1:0] dat,
                         input logic last, input logic flush);
        iwr_vld  = vld;
        iwr_dat  = dat;
        iwr_last = last;
        iflush   = flush;
    endtask

    task automatic push_exp(input logic [DWIDTH-1:0] w);
        for (int b = 0; b < DWIDTH/2; b++) exp_q.push_back({w[2*b], w[2*b+1]});
    endtask

    task automatic test_reset();
        irstb = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge ilaunch_clk);
        irstb = 1'b1;
        @(negedge ilaunch_clk);
        n_chk++;
        if (owr_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", owr_rdy);
        else n_pass++;
        n_chk++;
        if ({odat0, odat1, obusy} !== 3'b000)
            $display("FAIL reset_outputs: got odat0/odat1/obusy=%b%b%b want 000", odat0, odat1, obusy);
        else n_pass++;
`ifdef AIBCR3_TXSER_UNDERRUN_EN
        n_chk++;
        if (ounderrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", ounderrun);
        else n_pass++;
`endif
    endtask

    task automatic test_single();
        int first;
        logic [1:0] e;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ilaunch_clk);
            if (obusy) begin
                if (first < 0) first = k;
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL single_extra: pair %b%b emitted, none expected", odat0, odat1);
                else begin
                    e = exp_q.pop_front();
                    if ({odat0, odat1} !== e) $display("FAIL single_pair: got %b%b want %b", odat0, odat1, e);
                    else n_pass++;
                end
            end
            drive(k == 0, 8'hB4, 1'b1, 1'b0);
            if (k == 0) push_exp(8'hB4);
        end
        n_chk++;
        if (first !== 3) $display("FAIL single_latency: first busy at cycle %0d want 3", first);
        else n_pass++;
        n_chk++;
        if ({odat0, odat1, obusy} !== 3'b000)
            $display("FAIL single_idle: got odat0/odat1/obusy=%b%b%b want 000", odat0, odat1, obusy);
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL single_missing: %0d pairs never emitted want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first, last, nbusy;
        logic [1:0] e;
        first = -1; last = -1; nbusy = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge ilaunch_clk);
            if (obusy) begin
                if (first < 0) first = k;
                last = k;
                nbusy++;
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra: pair %b%b emitted, none expected", odat0, odat1);
                else begin
                    e = exp_q.pop_front();
                    if ({odat0, odat1} !== e) $display("FAIL b2b_pair: got %b%b want %b", odat0, odat1, e);
                    else n_pass++;
                end
            end
            drive(k < 2, (k == 0) ? 8'hFF : 8'h00, k == 1, 1'b0);
            if (k == 0) push_exp(8'hFF);
            if (k == 1) push_exp(8'h00);
        end
        n_chk++;
        if (nbusy !== 8) $display("FAIL b2b_busy_cycles: got %0d want 8", nbusy);
        else n_pass++;
        n_chk++;
        if (last - first + 1 !== 8) $display("FAIL b2b_gap: busy span %0d cycles want 8", last - first + 1);
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL b2b_missing: %0d pairs never emitted want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_full();
        logic [DWIDTH-1:0] words [6];
        logic              rdy_exp [7];
        logic [1:0]        e;
        words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 30; k++) begin
            @(negedge ilaunch_clk);
            if (obusy) begin
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL full_extra: pair %b%b emitted, none expected", odat0, odat1);
                else begin
                    e = exp_q.pop_front();
                    if ({odat0, odat1} !== e) $display("FAIL full_pair: got %b%b want %b", odat0, odat1, e);
                    else n_pass++;
                end
            end
            if (k < 7) begin
                n_chk++;
                if (owr_rdy !== rdy_exp[k]) $display("FAIL full_rdy[%0d]: got %b want %b", k, owr_rdy, rdy_exp[k]);
                else n_pass++;
            end
            drive(k < 6, (k < 6) ? words[k] : '0, k == 4, 1'b0);
            if (k < 6 && rdy_exp[k]) push_exp(words[k]);
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL full_missing: %0d pairs never emitted want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [1:0] e;
        for (int k = 0; k < 16; k++) begin
            @(negedge ilaunch_clk);
            if (obusy) begin
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL flush_extra: pair %b%b emitted, none expected", odat0, odat1);
                else begin
                    e = exp_q.pop_front();
                    if ({odat0, odat1} !== e) $display("FAIL flush_pair: got %b%b want %b", odat0, odat1, e);
                    else n_pass++;
                end
            end
            if (k == 5) begin
                n_chk++;
                if ({odat0, odat1, obusy, owr_rdy} !== 4'b0001)
                    $display("FAIL flush_after: got odat0/odat1/obusy/rdy=%b%b%b%b want 0001",
                             odat0, odat1, obusy, owr_rdy);
                else n_pass++;
            end
            case (k)
                0:       drive(1'b1, 8'hB4, 1'b1, 1'b0);
                1:       drive(1'b1, 8'hAA, 1'b0, 1'b0);
                2:       drive(1'b1, 8'hCC, 1'b1, 1'b0);
                4:       drive(1'b1, 8'h77, 1'b1, 1'b1);
                default: drive(1'b0, '0, 1'b0, 1'b0);
            endcase
            // Only the first two beats of 8'hB4 get out before the flush lands.
            if (k == 0) begin
                exp_q.push_back(2'b00);
                exp_q.push_back(2'b10);
            end
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL flush_missing: %0d pairs never emitted want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [1:0] e;
        for (int k = 0; k < 5; k++) begin
            @(negedge ilaunch_clk);
            if (obusy) begin
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL arst_extra: pair %b%b emitted, none expected", odat0, odat1);
                else begin
                    e = exp_q.pop_front();
                    if ({odat0, odat1} !== e) $display("FAIL arst_pair: got %b%b want %b", odat0, odat1, e);
                    else n_pass++;
                end
            end
            drive(k == 0, 8'hB4, 1'b1, 1'b0);
            if (k == 0) push_exp(8'hB4);
        end
        n_chk++;
        if (obusy !== 1'b1) $display("FAIL arst_midword: obusy=%b want 1 before reset", obusy);
        else n_pass++;
        #2 irstb = 1'b0;
        #1;
        n_chk++;
        if ({odat0, odat1, obusy} !== 3'b000)
            $display("FAIL arst_immediate: got odat0/odat1/obusy=%b%b%b want 000", odat0, odat1, obusy);
        else n_pass++;
        exp_q.delete();
        @(negedge ilaunch_clk);
        @(negedge ilaunch_clk);
        irstb = 1'b1;
        #1;
        n_chk++;
        if (owr_rdy !== 1'b1) $display("FAIL arst_rdy: got %b want 1", owr_rdy);
        else n_pass++;
        test_single();
    endtask

`ifdef AIBCR3_TXSER_UNDERRUN_EN
    task automatic test_underrun();
        logic [1:0] e;
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k < 13; k++) begin
                @(negedge ilaunch_clk);
                if (obusy) begin
                    n_chk++;
                    if (exp_q.size() == 0) $display("FAIL urun_extra: pair %b%b emitted, none expected", odat0, odat1);
                    else begin
                        e = exp_q.pop_front();
                        if ({odat0, odat1} !== e) $display("FAIL urun_pair: got %b%b want %b", odat0, odat1, e);
                        else n_pass++;
                    end
                end
                if (run == 0 && (k == 5 || k == 6 || k == 9 || k == 11)) begin
                    n_chk++;
                    if (ounderrun !== (k == 6 || k == 9))
                        $display("FAIL urun_flag[%0d]: got %b want %b", k, ounderrun, (k == 6 || k == 9));
                    else n_pass++;
                end
                if (run == 1 && k == 12) begin
                    n_chk++;
                    if (ounderrun !== 1'b0) $display("FAIL urun_last_tag: got %b want 0", ounderrun);
                    else n_pass++;
                end
                drive(k == 0, 8'h5A, run == 1, 1'b0);
                iclr_err = (run == 0 && k == 9);
                if (k == 0) push_exp(8'h5A);
            end
        end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL urun_missing: %0d pairs never emitted want 0", exp_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_flush();
        test_async_reset();
`ifdef AIBCR3_TXSER_UNDERRUN_EN
        test_underrun();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
